// File: rtl/aes_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM start/complete port among NUM_REQ AES engine controllers.
// Transactions are serialised through IDLE -> WAIT -> RELEASE and never aborted once issued.
module aes_bram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                       aes_clk,
    input  logic                       aes_rst_n,
    input  logic [NUM_REQ-1:0]         req_start_read,
    input  logic [NUM_REQ-1:0]         req_start_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_write_data,
    output logic [NUM_REQ-1:0]         req_complete,
    output logic [DATA_W-1:0]          req_read_data,
    output logic                       bram_start_read,
    output logic                       bram_start_write,
    output logic [ADDR_W-1:0]          bram_addr,
    output logic [DATA_W-1:0]          bram_write_data,
    input  logic [DATA_W-1:0]          bram_read_data,
    input  logic                       bram_complete,
    output logic [2:0]                 grant_id,
    output logic                       busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]         state_r;
    logic [2:0]         rr_r;
    logic               is_read_r;

    logic               any_s;
    logic [2:0]         pick_s;
    logic               pick_rd_s;
    logic               pick_wr_s;
    logic [ADDR_W-1:0]  pick_addr_s;
    logic [DATA_W-1:0]  pick_wdata_s;
    logic [NUM_REQ-1:0] done_onehot_s;
    logic [2:0]         next_rr_s;
    logic               take_s;
    int                 off_s;
    int                 best_s;

    // Round-robin pick: the active requester with the smallest distance from rr wins.
    always_comb begin
        any_s        = 1'b0;
        pick_s       = 3'd0;
        pick_rd_s    = 1'b0;
        pick_wr_s    = 1'b0;
        pick_addr_s  = {ADDR_W{1'b0}};
        pick_wdata_s = {DATA_W{1'b0}};
        take_s       = 1'b0;
        off_s        = 0;
        best_s       = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            off_s  = (i >= int'(rr_r)) ? (i - int'(rr_r)) : (i - int'(rr_r) + NUM_REQ);
            take_s = (req_start_read[i] || req_start_write[i]) && (off_s < best_s);
            best_s       = take_s ? off_s : best_s;
            any_s        = take_s ? 1'b1 : any_s;
            pick_s       = take_s ? 3'(i) : pick_s;
            pick_rd_s    = take_s ? req_start_read[i] : pick_rd_s;
            pick_wr_s    = take_s ? req_start_write[i] : pick_wr_s;
            pick_addr_s  = take_s ? req_addr[i*ADDR_W +: ADDR_W] : pick_addr_s;
            pick_wdata_s = take_s ? req_write_data[i*DATA_W +: DATA_W] : pick_wdata_s;
        end
    end

    // Completion one-hot for the granted requester and the rotated rr pointer.
    always_comb begin
        done_onehot_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            done_onehot_s[i] = (grant_id == 3'(i));
        end
        next_rr_s = (grant_id >= 3'(NUM_REQ - 1)) ? 3'd0 : (grant_id + 3'd1);
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state_r          <= ST_IDLE;
            rr_r             <= 3'd0;
            is_read_r        <= 1'b0;
            req_complete     <= {NUM_REQ{1'b0}};
            req_read_data    <= {DATA_W{1'b0}};
            bram_start_read  <= 1'b0;
            bram_start_write <= 1'b0;
            bram_addr        <= {ADDR_W{1'b0}};
            bram_write_data  <= {DATA_W{1'b0}};
            grant_id         <= 3'd0;
            busy             <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_complete <= {NUM_REQ{1'b0}};
                    if (any_s) begin
                        bram_addr        <= pick_addr_s;
                        bram_write_data  <= pick_wdata_s;
                        grant_id         <= pick_s;
                        // Read wins when both strobes are up; the write is granted later.
                        bram_start_read  <= pick_rd_s;
                        bram_start_write <= pick_wr_s & ~pick_rd_s;
                        is_read_r        <= pick_rd_s;
                        busy             <= 1'b1;
                        state_r          <= ST_WAIT;
                    end else begin
                        bram_start_read  <= 1'b0;
                        bram_start_write <= 1'b0;
                        busy             <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bram_complete) begin
                        bram_start_read  <= 1'b0;
                        bram_start_write <= 1'b0;
                        req_complete     <= done_onehot_s;
                        if (is_read_r) begin
                            req_read_data <= bram_read_data;
                        end else begin
                            req_read_data <= req_read_data;
                        end
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RELEASE: begin
                    req_complete <= {NUM_REQ{1'b0}};
                    rr_r         <= next_rr_s;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    req_complete     <= {NUM_REQ{1'b0}};
                    bram_start_read  <= 1'b0;
                    bram_start_write <= 1'b0;
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_bram_arbiter.sv
// Scoreboard bench for aes_bram_arbiter: expected grants/completions are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT presents a grant or completion.
module tb_aes_bram_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LAT     = 3;

    logic                 aes_clk;
    logic                 aes_rst_n;
    logic [NUM_REQ-1:0]   req_start_read;
    logic [NUM_REQ-1:0]   req_start_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_write_data;
    logic [NUM_REQ-1:0]   req_complete;
    logic [DW-1:0]        req_read_data;
    logic                 bram_start_read;
    logic                 bram_start_write;
    logic [AW-1:0]        bram_addr;
    logic [DW-1:0]        bram_write_data;
    logic [DW-1:0]        bram_read_data;
    logic                 bram_complete;
    logic [2:0]           grant_id;
    logic                 busy;

    aes_bram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aes_clk          (aes_clk),
        .aes_rst_n        (aes_rst_n),
        .req_start_read   (req_start_read),
        .req_start_write  (req_start_write),
        .req_addr         (req_addr),
        .req_write_data   (req_write_data),
        .req_complete     (req_complete),
        .req_read_data    (req_read_data),
        .bram_start_read  (bram_start_read),
        .bram_start_write (bram_start_write),
        .bram_addr        (bram_addr),
        .bram_write_data  (bram_write_data),
        .bram_read_data   (bram_read_data),
        .bram_complete    (bram_complete),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    typedef struct {
        logic [2:0]  id;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic [1:0]  onehot;
        logic        rd;
        logic [31:0] data;
    } comp_t;

    grant_t gq[$];
    comp_t  cq[$];

    int vectors     = 0;
    int miscompares = 0;
    int comp_cnt [NUM_REQ];
    bit bram_en;

    int          pend  [NUM_REQ];
    bit          d_rd  [NUM_REQ];
    bit          d_wr  [NUM_REQ];
    logic [31:0] d_addr[NUM_REQ];
    logic [31:0] d_wd  [NUM_REQ];

    initial aes_clk = 1'b0;
    always #5 aes_clk = ~aes_clk;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic exp_grant(input int id, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        grant_t g;
        g.id = 3'(id); g.rd = rd; g.wr = wr; g.addr = a; g.wdata = wd;
        gq.push_back(g);
    endtask

    task automatic exp_comp(input int id, input bit rd, input logic [31:0] data);
        comp_t c;
        c.onehot = 2'b01 << id; c.rd = rd; c.data = data;
        cq.push_back(c);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_complete"}, 64'(req_complete), 64'd0);
        chk({tag, "_req_read_data"}, 64'(req_read_data), 64'd0);
        chk({tag, "_bram_strobes"}, {62'd0, bram_start_read, bram_start_write}, 64'd0);
        chk({tag, "_bram_addr"}, 64'(bram_addr), 64'd0);
        chk({tag, "_bram_write_data"}, 64'(bram_write_data), 64'd0);
        chk({tag, "_grant_id_busy"}, {60'd0, grant_id, busy}, 64'd0);
    endtask

    task automatic wait_comp(input int id, input string name);
        int n = 0;
        @(negedge aes_clk);
        while (!req_complete[id] && n < 40) begin
            @(negedge aes_clk);
            n++;
        end
        if (!req_complete[id]) timeout_fail(name);
    endtask

    // One negedge of the generic requester model: drop on complete, re-raise a cycle later.
    task automatic drv_step();
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((req_start_read[i] || req_start_write[i]) && req_complete[i]) begin
                req_start_read[i]  = 1'b0;
                req_start_write[i] = 1'b0;
                pend[i]--;
            end else if (!(req_start_read[i] || req_start_write[i]) && pend[i] > 0) begin
                req_addr[i*AW +: AW]       = d_addr[i];
                req_write_data[i*DW +: DW] = d_wd[i];
                req_start_read[i]          = d_rd[i];
                req_start_write[i]         = d_wr[i];
            end
        end
    endtask

    task automatic run_driver(input int budget, input string name);
        int n = 0;
        drv_step();
        while ((pend[0] > 0 || pend[1] > 0 || busy) && n < budget) begin
            @(negedge aes_clk);
            drv_step();
            n++;
        end
        if (n >= budget) timeout_fail(name);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge aes_clk);
        #2 aes_rst_n = 1'b0;
        #1 chk_all_zero(tag);
        @(negedge aes_clk);
        aes_rst_n = 1'b1;
    endtask

    // BRAM port model: completes LAT negedges after the strobe is seen.
    initial begin
        int cnt = 0;
        bram_complete  = 1'b0;
        bram_read_data = 32'h0;
        forever begin
            @(negedge aes_clk);
            if (!aes_rst_n || !bram_en || !(bram_start_read || bram_start_write)) begin
                bram_complete = 1'b0;
                cnt = 0;
            end else if (cnt == LAT) begin
                bram_complete = 1'b1;
                if (bram_start_read) bram_read_data = bram_word(bram_addr);
                cnt = 0;
            end else begin
                bram_complete = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: compares each new grant and each completion pulse against the scoreboard.
    initial begin
        bit prev_strobe = 1'b0;
        grant_t g;
        comp_t  c;
        forever begin
            @(negedge aes_clk);
            if (!aes_rst_n) begin
                prev_strobe = 1'b0;
            end else begin
                if ((bram_start_read || bram_start_write) && !prev_strobe) begin
                    if (gq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_grant: grant_id %0d with empty scoreboard", grant_id);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_id", 64'(grant_id), 64'(g.id));
                        chk("grant_op", {62'd0, bram_start_read, bram_start_write}, {62'd0, g.rd, g.wr});
                        chk("grant_addr", 64'(bram_addr), 64'(g.addr));
                        if (g.wr) chk("grant_wdata", 64'(bram_write_data), 64'(g.wdata));
                    end
                end
                prev_strobe = bram_start_read || bram_start_write;
                if (req_complete != 2'b00) begin
                    for (int i = 0; i < NUM_REQ; i++) if (req_complete[i]) comp_cnt[i]++;
                    if (cq.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_complete: req_complete %b with empty scoreboard", req_complete);
                    end else begin
                        c = cq.pop_front();
                        chk("complete_onehot", 64'(req_complete), 64'(c.onehot));
                        if (c.rd) chk("read_data", 64'(req_read_data), 64'(c.data));
                    end
                end
            end
        end
    end

    initial begin
        aes_rst_n       = 1'b0;
        bram_en         = 1'b1;
        req_start_read  = 2'b00;
        req_start_write = 2'b00;
        req_addr        = 64'd0;
        req_write_data  = 64'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 0; comp_cnt[i] = 0;
        end

        // Power-on reset
        repeat (2) @(negedge aes_clk);
        chk_all_zero("por");
        aes_rst_n = 1'b1;

        // 1. Reset asserted mid-WAIT drops the transaction
        bram_en = 1'b0;
        @(negedge aes_clk);
        req_addr[0 +: AW] = 32'h0000_0080;
        req_start_read[0] = 1'b1;
        exp_grant(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        repeat (3) @(negedge aes_clk);
        chk("midwait_strobe", 64'(bram_start_read), 64'd1);
        req_start_read[0] = 1'b0;
        #2 aes_rst_n = 1'b0;
        #1 chk_all_zero("midwait_rst");
        @(negedge aes_clk);
        aes_rst_n = 1'b1;
        bram_en   = 1'b1;
        repeat (8) @(negedge aes_clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // 2. Single read with fixed latency
        req_addr[0 +: AW] = 32'h0000_0010;
        req_start_read[0] = 1'b1;
        exp_grant(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        exp_comp(0, 1'b1, 32'hDEAD_BEEF);
        @(negedge aes_clk);
        chk("single_strobe", 64'(bram_start_read), 64'd1);
        chk("single_addr", 64'(bram_addr), 64'h10);
        wait_comp(0, "single_complete");
        chk("single_busy_release", 64'(busy), 64'd1);
        req_start_read[0] = 1'b0;
        @(negedge aes_clk);
        chk("single_busy_idle", 64'(busy), 64'd0);
        chk("single_pulse_width", 64'(req_complete), 64'd0);

        reset_pulse("rst2");

        // 3. Simultaneous write (req 0) and read (req 1)
        pend[0] = 1; d_rd[0] = 1'b0; d_wr[0] = 1'b1; d_addr[0] = 32'h100; d_wd[0] = 32'h1111_1111;
        pend[1] = 1; d_rd[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = 32'h200; d_wd[1] = 32'h0;
        exp_grant(0, 1'b0, 1'b1, 32'h100, 32'h1111_1111);
        exp_comp(0, 1'b0, 32'h0);
        exp_grant(1, 1'b1, 1'b0, 32'h200, 32'h0);
        exp_comp(1, 1'b1, 32'hC0DE_0200);
        @(negedge aes_clk);
        run_driver(100, "simultaneous");

        // 4. Saturation: 8 transactions alternate 0,1,...
        comp_cnt[0] = 0; comp_cnt[1] = 0;
        pend[0] = 4; d_rd[0] = 1'b0; d_wr[0] = 1'b1; d_addr[0] = 32'h300; d_wd[0] = 32'h2222_2222;
        pend[1] = 4; d_rd[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = 32'h400; d_wd[1] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            exp_grant(0, 1'b0, 1'b1, 32'h300, 32'h2222_2222);
            exp_comp(0, 1'b0, 32'h0);
            exp_grant(1, 1'b1, 1'b0, 32'h400, 32'h0);
            exp_comp(1, 1'b1, 32'hC0DE_0400);
        end
        @(negedge aes_clk);
        run_driver(400, "saturation");
        chk("sat_count_req0", 64'(comp_cnt[0]), 64'd4);
        chk("sat_count_req1", 64'(comp_cnt[1]), 64'd4);

        // 5. Requester 1 withdraws its write two cycles into WAIT
        @(negedge aes_clk);
        req_addr[AW +: AW]       = 32'h500;
        req_write_data[DW +: DW] = 32'h3333_3333;
        req_start_write[1]       = 1'b1;
        exp_grant(1, 1'b0, 1'b1, 32'h500, 32'h3333_3333);
        exp_comp(1, 1'b0, 32'h0);
        repeat (3) @(negedge aes_clk);
        req_start_write[1] = 1'b0;
        @(negedge aes_clk);
        chk("withdraw_strobe_held", 64'(bram_start_write), 64'd1);
        wait_comp(1, "withdraw_complete");
        repeat (8) @(negedge aes_clk);
        chk("withdraw_busy", 64'(busy), 64'd0);

        // 6. Read/write conflict on requester 0
        req_addr[0 +: AW]       = 32'h40;
        req_write_data[0 +: DW] = 32'h4444_4444;
        req_start_read[0]       = 1'b1;
        req_start_write[0]      = 1'b1;
        exp_grant(0, 1'b1, 1'b0, 32'h40, 32'h0);
        exp_comp(0, 1'b1, 32'hC0DE_0040);
        exp_grant(0, 1'b0, 1'b1, 32'h40, 32'h4444_4444);
        exp_comp(0, 1'b0, 32'h0);
        wait_comp(0, "conflict_read");
        req_start_read[0] = 1'b0;
        @(negedge aes_clk);
        wait_comp(0, "conflict_write");
        req_start_write[0] = 1'b0;
        repeat (4) @(negedge aes_clk);
        chk("conflict_rdata_hold", 64'(req_read_data), 64'hC0DE_0040);

        repeat (4) @(negedge aes_clk);
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("comp_queue_empty", 64'(cq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_bram_arbiter.md
Name: aes_bram_arbiter

Overview:
- Shares the single BRAM access port between NUM_REQ AES engine controllers.
- Each requester uses the same level start / complete handshake the engines already use toward BRAM: start_read or start_write held high until a complete pulse is returned.
- The block sits between the engine controllers and the AXI-side BRAM port, so several engines can stream chunks concurrently.
- It serialises transactions with round-robin fairness. It never aborts a transaction once issued.

Parameters:
- NUM_REQ, 2: number of requesting engines (2..8).
- ADDR_W, 32: BRAM byte-address width.
- DATA_W, 32: BRAM data word width.

Ports:
- aes_clk  in  1  single clock, all state updates on its rising edge.
- aes_rst_n  in  1  asynchronous, active-low reset.
- req_start_read  in  NUM_REQ  per-requester read request, level, held until its req_complete.
- req_start_write  in  NUM_REQ  per-requester write request, level, held until its req_complete.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W].
- req_write_data  in  NUM_REQ*DATA_W  per-requester write word, same slicing.
- req_complete  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_read_data  out  DATA_W  shared read return word; valid when a read's req_complete is high.
- bram_start_read  out  1  read strobe to the BRAM port, level.
- bram_start_write  out  1  write strobe to the BRAM port, level.
- bram_addr  out  ADDR_W  address of the granted transaction.
- bram_write_data  out  DATA_W  write word of the granted transaction.
- bram_read_data  in  DATA_W  read word from the BRAM port.
- bram_complete  in  1  transaction-done indication from the BRAM port.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- **Reset values.** Reset is asynchronous. All outputs go to 0, state goes to IDLE and the round-robin pointer rr goes to 0. Any transaction in flight is dropped and no req_complete is generated. The bench must not assume bram_complete is still honoured after reset.
- **Registers.** All outputs are registered. req_start_* and bram_complete are sampled at the rising edge.
- **State machine.** Three states: IDLE, WAIT, RELEASE.
- **IDLE.**
  - A requester is active if req_start_read[i] or req_start_write[i] is high.
  - If any requester is active, pick the first active index scanning rr, rr+1, ... modulo NUM_REQ. Call it g.
  - At that same edge:
    - latch bram_addr = req_addr[g] and bram_write_data = req_write_data[g];
    - set grant_id = g;
    - set bram_start_read = req_start_read[g], or bram_start_write = req_start_write[g] when no read is requested;
    - go to WAIT.
  - If g requests both read and write, the read wins. The write stays pending and is served as a later, separate grant.
  - If no requester is active, stay in IDLE with all strobes low.
- **WAIT.**
  - Hold the strobe, address and data stable until bram_complete is sampled high.
  - At that edge:
    - drop the strobe;
    - set req_complete[g] = 1;
    - if the transaction was a read, load req_read_data = bram_read_data;
    - go to RELEASE.
  - Dropping a request during WAIT has no effect; the transaction still completes and still pulses req_complete.
- **RELEASE.**
  - One cycle long. At the next edge: req_complete goes to 0, rr = (g+1) mod NUM_REQ, state goes to IDLE.
  - This gap lets the requester drop its start on the edge where it sees complete, so a stale request is never re-granted.
- **Latency.** A request sampled at edge k has its strobe high after edge k. bram_complete sampled at edge m gives req_complete high during cycle m+1. The next grant can occur at edge m+2, so per-transaction overhead is 2 cycles plus BRAM latency.
- **Read data hold.** req_read_data holds its value until the next read completes; writes do not modify it.
- **Ignored inputs.** bram_complete is ignored in IDLE and RELEASE. A request from a non-granted requester is ignored until the next IDLE.
- **Fairness.** With all requesters continuously active, grants are strictly round-robin 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- **Unused grant bits.** grant_id bits above clog2(NUM_REQ) are 0.

Test Plan:
1. **Reset state.** Assert aes_rst_n=0 mid-WAIT with bram_start_read=1 → all outputs 0 immediately. After release, with no requests, busy=0 and no req_complete pulse ever appears.
2. **Single read, fixed latency.** Requester 0 reads addr 0x0000_0010; BRAM returns 0xDEADBEEF after 3 cycles of complete latency.
   - Expect bram_start_read=1 and bram_addr=0x10 one cycle after the request.
   - Expect req_complete[0] high for exactly 1 cycle with req_read_data=0xDEADBEEF.
   - Expect busy to return to 0 two cycles after bram_complete.
3. **Simultaneous requests.** Requester 0 writes 0x11111111 to 0x100 while requester 1 reads 0x200, both from the same cycle.
   - Expect the grant to requester 0 first (rr=0), then requester 1.
   - Expect bram_write_data=0x11111111 during the first grant and grant_id sequence 0,1.
4. **Round-robin under saturation.** NUM_REQ=2, both requesters re-request immediately after each completion for 8 transactions → grant_id alternates 0,1,0,1,... and each requester sees exactly 4 req_complete pulses.
5. **Withdraw during WAIT.** Requester 1 drops req_start_write two cycles into WAIT → bram_start_write stays high until bram_complete, req_complete[1] still pulses, and no second grant is issued to requester 1.
6. **Read/write conflict.** Requester 0 raises both strobes with addr 0x40 → a read is issued first. After the read's req_complete and RELEASE, a write to 0x40 is issued if the write is still held, and req_read_data is unchanged by the write.
